// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge.
package sram_bridge_pkg;

    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned NUM_WMASKS        = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

endpackage

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave that maps a word window onto SRAM port 0
// (inputs latched on posedge, read data updated on negedge).
module sram_wb_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [NUM_WMASKS-1:0]   wb_sel_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_ack_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    csb0,
    output logic                    web0,
    output logic [NUM_WMASKS-1:0]   wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
);

    state_t                  r_state;
    logic                    r_we;
    logic                    r_live;
    logic                    r_ack;
    logic                    r_csb;
    logic                    r_web;
    logic [NUM_WMASKS-1:0]   r_wmask;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;
    logic [DATA_WIDTH-1:0]   r_dat;

    logic                    w_req;
    logic                    w_hit;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_hit    = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_word   = wb_adr_i[ADDR_WIDTH+1:2];
    assign w_unused = ^wb_adr_i[1:0];

    // Ack is also gated by the live cycle so an abandoned cycle never sees a pulse.
    assign wb_ack_o = r_ack & wb_cyc_i;
    assign wb_dat_o = r_dat;
    assign csb0     = r_csb;
    assign web0     = r_web;
    assign wmask0   = r_wmask;
    assign addr0    = r_addr;
    assign din0     = r_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_live  <= 1'b0;
            r_ack   <= 1'b0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req) begin
                        if (w_hit) begin
                            // Port-0 controls are loaded here so they are valid for all of ISSUE.
                            r_we    <= wb_we_i;
                            r_live  <= 1'b1;
                            r_csb   <= 1'b0;
                            r_web   <= ~wb_we_i;
                            r_wmask <= wb_we_i ? wb_sel_i : '0;
                            r_addr  <= w_word;
                            r_din   <= wb_dat_i;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_dat   <= '0;
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_wmask <= '0;
                    if (r_we) begin
                        r_ack   <= r_live & wb_cyc_i;
                        r_state <= ST_ACK;
                    end else begin
                        r_live  <= r_live & wb_cyc_i;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_dat   <= dout0;
                    r_ack   <= r_live & wb_cyc_i;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_live  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Directed and random Wishbone transactions against a behavioural SRAM,
// checked against a word-array reference of the window.
module tb_sram_wb_bridge;

    localparam int unsigned AW   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [AW-1:0] addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    sram_wb_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: controls latched on posedge, write/read on negedge,
    // read data undefined again from the following posedge.
    logic [31:0]   sram [256] = '{default: '0};
    logic          l_csb = 1'b1;
    logic          l_web = 1'b1;
    logic [3:0]    l_mask = '0;
    logic [AW-1:0] l_addr = '0;
    logic [31:0]   l_din = '0;

    always @(clk) begin
        if (clk) begin
            l_csb  <= csb0;
            l_web  <= web0;
            l_mask <= wmask0;
            l_addr <= addr0;
            l_din  <= din0;
            dout0  <= 'x;
        end else if (l_csb === 1'b0) begin
            if (l_web === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (l_mask[b]) sram[l_addr][8*b +: 8] <= l_din[8*b +: 8];
            end else begin
                dout0 <= sram[l_addr];
            end
        end
    end

    int            csb_low = 0;
    logic          mon_web;
    logic [3:0]    mon_mask;
    logic [AW-1:0] mon_addr;
    logic [31:0]   mon_din;

    always @(negedge clk) begin
        if (csb0 === 1'b0) begin
            csb_low  = csb_low + 1;
            mon_web  = web0;
            mon_mask = wmask0;
            mon_addr = addr0;
            mon_din  = din0;
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [256] = '{default: '0};
    logic [31:0] exp_dat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_csb0"},   32'(csb0),     32'd1);
        chk({tag, "_web0"},   32'(web0),     32'd1);
        chk({tag, "_wmask0"}, 32'(wmask0),   32'd0);
        chk({tag, "_addr0"},  32'(addr0),    32'd0);
        chk({tag, "_din0"},   din0,          32'd0);
        chk({tag, "_ack"},    32'(wb_ack_o), 32'd0);
        chk({tag, "_dat"},    wb_dat_o,      32'd0);
    endtask

    // Called at a negedge with the bridge idle; returns at the negedge of the
    // idle cycle that follows the ack, with the bus released.
    task automatic txn(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] data);
        bit          hit;
        int unsigned w;
        int          lat;
        int          exp_lat;
        int          c0;
        logic [31:0] m;
        hit = ((adr >> (AW + 2)) == (BASE >> (AW + 2)));
        w   = (adr >> 2) % (1 << AW);
        exp_lat = !hit ? 1 : (we ? 2 : 3);
        if (!hit) begin
            exp_dat = '0;
        end else if (we) begin
            m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            ref_mem[w] = (ref_mem[w] & ~m) | (data & m);
        end else begin
            exp_dat = ref_mem[w];
        end
        c0 = csb_low;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_sel_i = sel;  wb_adr_i = adr;  wb_dat_i = data;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("wb_dat_o", wb_dat_o, exp_dat);
        @(negedge clk);
        chk("ack_one_cycle", 32'(wb_ack_o), 32'd0);
        chk("idle_gap_csb0", 32'(csb0), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        chk("csb0_cycles", 32'(csb_low - c0), hit ? 32'd1 : 32'd0);
        if (hit) begin
            chk("addr0", 32'(mon_addr), 32'(w));
            chk("web0", 32'(mon_web), we ? 32'd0 : 32'd1);
            chk("wmask0", 32'(mon_mask), we ? 32'(sel) : 32'd0);
            if (we) chk("din0", mon_din, data);
        end
    endtask

    initial begin
        int          acks;
        int          c0;
        bit          rw;
        logic [31:0] adr;
        int unsigned r;

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Accepted on the first posedge after reset release.
        txn(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
        txn(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        chk("rd_deadbeef", wb_dat_o, 32'hDEADBEEF);

        txn(1'b1, 4'hF, BASE + 32'h04, 32'hFFFFFFFF);
        txn(1'b1, 4'h1, BASE + 32'h04, 32'h00000012);
        txn(1'b0, 4'hF, BASE + 32'h04, 32'h0);
        chk("rd_byte_merge", wb_dat_o, 32'hFFFFFF12);

        txn(1'b1, 4'h0, BASE + 32'h04, 32'hA5A5A5A5);
        txn(1'b0, 4'hF, BASE + 32'h04, 32'h0);
        chk("rd_sel0_write", wb_dat_o, 32'hFFFFFF12);

        txn(1'b0, 4'hF, BASE + 32'h400, 32'h0);
        chk("rd_miss_zero", wb_dat_o, 32'h0);

        txn(1'b0, 4'hF, BASE + 32'h13, 32'h0);
        chk("rd_low_bits_ignored", wb_dat_o, 32'hDEADBEEF);

        // Cycle abandoned while the read is in WAIT.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_sel_i = 4'hF; wb_adr_i = BASE + 32'h10;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (wb_ack_o !== 1'b0) acks++;
        end
        chk("drop_no_ack", 32'(acks), 32'd0);
        chk("drop_dat_loaded", wb_dat_o, 32'hDEADBEEF);
        txn(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        chk("rd_after_drop", wb_dat_o, 32'hDEADBEEF);

        // Reset during ISSUE of a write.
        txn(1'b1, 4'hF, BASE + 32'h20, 32'hA5A50F0F);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_sel_i = 4'hF; wb_adr_i = BASE + 32'h20; wb_dat_i = 32'h12345678;
        @(posedge clk);
        c0 = csb_low;
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_issue");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_ack_o !== 1'b0) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        chk("rst_no_access", 32'(csb_low - c0), 32'd0);
        exp_dat = '0;
        txn(1'b0, 4'hF, BASE + 32'h20, 32'h0);
        chk("rd_after_abort", wb_dat_o, 32'hA5A50F0F);

        // Back-to-back reads across the window.
        txn(1'b1, 4'hF, BASE + 32'h000, 32'h0BAD_F00D);
        txn(1'b1, 4'hF, BASE + 32'h3FC, 32'hCAFE_0001);
        txn(1'b1, 4'hF, BASE + 32'h200, 32'h1357_9BDF);
        txn(1'b0, 4'hF, BASE + 32'h000, 32'h0);
        chk("b2b_word0", wb_dat_o, 32'h0BAD_F00D);
        txn(1'b0, 4'hF, BASE + 32'h3FC, 32'h0);
        chk("b2b_word255", wb_dat_o, 32'hCAFE_0001);
        txn(1'b0, 4'hF, BASE + 32'h200, 32'h0);
        chk("b2b_word128", wb_dat_o, 32'h1357_9BDF);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom;
            rw = r[1];
            if (r % 6 == 0) adr = $urandom;
            else adr = BASE + (32'($urandom_range(0, 15)) << 2) + ((r >> 8) & 32'd3);
            txn(rw, 4'($urandom_range(0, 15)), adr, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
